e_alu_iq: RTL and testbench
===========================

Name: e_alu_iq

Overview:
- Collapsing, age-ordered issue queue that feeds the integer ALU execute stage.
- Accepts renamed ALU micro-ops from dispatch and tracks source-operand readiness via writeback wakeup broadcasts.
- Each cycle, presents the oldest fully-ready entry to the ALU stage over a valid/ready handshake.
- The payload fields match the ALU operation encoding: grand_op/op/pc/imm.

Parameters:
- DEPTH, 8, number of queue entries (power of 2 not required, ≥2).
- TAG_W, 6, physical register tag width.
- WK_N, 2, number of wakeup broadcast ports per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush; clears the whole queue.
- disp_valid_i  in  1  dispatch offers one micro-op.
- disp_ready_o  out  1  queue can accept a micro-op.
- disp_grand_op_i  in  3  ALU grand op class.
- disp_op_i  in  3  ALU sub-op.
- disp_pc_i  in  32  instruction PC.
- disp_imm_i  in  32  immediate.
- disp_psrc0_i, disp_psrc1_i  in  TAG_W each  source tags.
- disp_src0_rdy_i, disp_src1_rdy_i  in  1 each  source already available at dispatch.
- disp_pdst_i  in  TAG_W  destination tag.
- wk_valid_i  in  WK_N  wakeup strobes.
- wk_tag_i  in  WK_N*TAG_W  wakeup tags, port k at [k*TAG_W +: TAG_W].
- iss_valid_o  out  1  selected entry offered to the ALU.
- iss_ready_i  in  1  ALU stage accepts.
- iss_grand_op_o, iss_op_o  out  3 each  selected payload.
- iss_pc_o, iss_imm_o  out  32 each  selected payload.
- iss_psrc0_o, iss_psrc1_o, iss_pdst_o  out  TAG_W each  selected tags.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- State: count register plus DEPTH entries {payload, rdy0, rdy1}. Valid entries occupy indices 0..count-1; index 0 is the oldest.
- Reset (rst high at posedge): count=0 and all rdy bits cleared. Next cycle: iss_valid_o=0, disp_ready_o=1, count_o=0. rst has priority over flush and all other inputs.
- disp_ready_o = (count < DEPTH). It is purely registered-state derived, so a full queue does not accept even when an issue occurs in the same cycle.
- Dispatch fires on disp_valid_i && disp_ready_o. The new entry is written at index count, or count-1 if an issue also fires that cycle.
- Tag 0 is the hardwired zero register:
  - A source with tag 0 is stored ready regardless of disp_srcN_rdy_i.
  - A wakeup with tag 0 is ignored.
- Wakeup: for each k with wk_valid_i[k], every valid entry whose psrcN equals wk_tag_i[k] sets rdyN at the clock edge.
- Wakeup also applies to the entry being dispatched in the same cycle (bypass), so its stored rdy reflects the match.
- A wakeup in cycle N makes an entry eligible for issue in cycle N+1. There is no combinational wakeup-to-issue path.
- Select: iss_valid_o = OR of (rdy0 && rdy1) over valid entries, forced to 0 while flush_i=1. The payload is the lowest-index eligible entry.
- The outputs are combinational from registered state. They may change while iss_ready_i=0 if an older entry becomes eligible.
- Issue fires on iss_valid_o && iss_ready_i. At the edge the issued entry is removed, entries above it shift down one index with their rdy bits, and wakeups apply to the shifted copies.
- Same-cycle dispatch + issue: count is unchanged and age order is preserved; the new entry lands at the top.
- Flush: at the edge, count=0. A dispatch or issue in the flush cycle is discarded; the ALU must not capture with iss_valid_o=0.
- Duplicate wakeup tags on both ports in one cycle are legal and equivalent to a single wakeup.
- An entry with psrc0==psrc1 is woken on both sources by one broadcast.
- count_o always equals the number of valid entries. Underflow and overflow are impossible by construction.

Test Plan:
- Reset, then dispatch 3 ops with all sources ready (ADD pc=0x1000, SUB pc=0x1004, SLT pc=0x1008), iss_ready_i=1 -> issued in order 0x1000, 0x1004, 0x1008 in consecutive cycles, count_o returns to 0.
- Dispatch op A (psrc0=5, not ready) then op B (all ready) -> B issues first. Pulse wk_tag=5 in cycle N -> A has iss_valid_o=1 in N+1, not in N.
- Fill 8 entries with psrc1=9 not ready -> disp_ready_o=0 and count_o=8. Wakeup tag 9 -> all 8 issue oldest-first over 8 cycles; disp_ready_o=1 after the first issue edge.
- Dispatch with psrc0=7 not ready in the same cycle as wk_tag=7 -> the entry is issuable next cycle (bypass). Dispatch with psrc1=0, src1_rdy=0 -> treated ready.
- iss_ready_i=0 with 4 ready entries for 3 cycles -> iss_pc_o holds the oldest and count_o=4. Then dispatch+issue together for 4 cycles -> count_o stays 4 and order is preserved.
- 5 entries queued, flush_i=1 with disp_valid_i=1 and iss_ready_i=1 -> iss_valid_o=0 that cycle, count_o=0 next. Assert rst mid-fill -> same empty state next cycle.

Source files
------------

// File: rtl/e_alu_iq.sv
// e_alu_iq: collapsing, age-ordered issue queue for the integer ALU.
// Entries 0..count-1 are valid, index 0 is the oldest. Each cycle the
// lowest-index entry with both sources ready is offered to the ALU. Issued
// entries collapse the queue, and wakeup broadcasts set source-ready bits at
// the clock edge.

module e_alu_iq #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int WK_N  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  logic [2:0]                 disp_grand_op_i,
  input  logic [2:0]                 disp_op_i,
  input  logic [31:0]                disp_pc_i,
  input  logic [31:0]                disp_imm_i,
  input  logic [TAG_W-1:0]           disp_psrc0_i,
  input  logic [TAG_W-1:0]           disp_psrc1_i,
  input  logic                       disp_src0_rdy_i,
  input  logic                       disp_src1_rdy_i,
  input  logic [TAG_W-1:0]           disp_pdst_i,
  input  logic [WK_N-1:0]            wk_valid_i,
  input  logic [WK_N*TAG_W-1:0]      wk_tag_i,
  output logic                       iss_valid_o,
  input  logic                       iss_ready_i,
  output logic [2:0]                 iss_grand_op_o,
  output logic [2:0]                 iss_op_o,
  output logic [31:0]                iss_pc_o,
  output logic [31:0]                iss_imm_o,
  output logic [TAG_W-1:0]           iss_psrc0_o,
  output logic [TAG_W-1:0]           iss_psrc1_o,
  output logic [TAG_W-1:0]           iss_pdst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [2:0]       grand_op;
    logic [2:0]       op;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] psrc0;
    logic [TAG_W-1:0] psrc1;
    logic [TAG_W-1:0] pdst;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           disp_ent;
  logic [DEPTH-1:0] rdy0_q, rdy1_q, rdy0_d, rdy1_d;
  logic [DEPTH-1:0] wake0, wake1;
  logic             disp_wake0, disp_wake1;
  logic [CW-1:0]    count_q, count_d, wr_idx;
  logic [IW-1:0]    sel_idx;
  logic             any_elig, issue_fire, disp_fire;

  assign disp_ready_o = (count_q < CW'(DEPTH));
  assign disp_fire    = disp_valid_i && disp_ready_o;
  assign iss_valid_o  = any_elig && !flush_i;
  assign issue_fire   = iss_valid_o && iss_ready_i;
  assign wr_idx       = count_q - CW'(issue_fire);
  assign count_o      = count_q;

  // Pack the dispatch fields into an entry record
  always_comb begin
    disp_ent.grand_op = disp_grand_op_i;
    disp_ent.op       = disp_op_i;
    disp_ent.pc       = disp_pc_i;
    disp_ent.imm      = disp_imm_i;
    disp_ent.psrc0    = disp_psrc0_i;
    disp_ent.psrc1    = disp_psrc1_i;
    disp_ent.pdst     = disp_pdst_i;
  end

  // Match wakeup tags against stored and incoming sources; tag 0 never wakes
  always_comb begin
    wake0      = '0;
    wake1      = '0;
    disp_wake0 = 1'b0;
    disp_wake1 = 1'b0;
    for (int k = 0; k < WK_N; k++) begin
      if (wk_valid_i[k] && (wk_tag_i[k*TAG_W +: TAG_W] != '0)) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (ent_q[j].psrc0 == wk_tag_i[k*TAG_W +: TAG_W]) wake0[j] = 1'b1;
          if (ent_q[j].psrc1 == wk_tag_i[k*TAG_W +: TAG_W]) wake1[j] = 1'b1;
        end
        if (disp_psrc0_i == wk_tag_i[k*TAG_W +: TAG_W]) disp_wake0 = 1'b1;
        if (disp_psrc1_i == wk_tag_i[k*TAG_W +: TAG_W]) disp_wake1 = 1'b1;
      end
    end
  end

  // Pick the oldest valid entry whose sources are both ready
  always_comb begin
    sel_idx  = '0;
    any_elig = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if ((i < int'(count_q)) && rdy0_q[i] && rdy1_q[i]) begin
        sel_idx  = IW'(i);
        any_elig = 1'b1;
      end
    end
  end

  // Next queue image: collapse above the issued slot, apply wakeups, append dispatch
  always_comb begin
    count_d = count_q;
    if (disp_fire && !issue_fire)      count_d = count_q + CW'(1);
    else if (!disp_fire && issue_fire) count_d = count_q - CW'(1);

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i]  = ent_q[i];
      rdy0_d[i] = rdy0_q[i] | wake0[i];
      rdy1_d[i] = rdy1_q[i] | wake1[i];
    end
    for (int i = 0; i < DEPTH-1; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) begin
        ent_d[i]  = ent_q[i+1];
        rdy0_d[i] = rdy0_q[i+1] | wake0[i+1];
        rdy1_d[i] = rdy1_q[i+1] | wake1[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && (i == int'(wr_idx))) begin
        ent_d[i]  = disp_ent;
        rdy0_d[i] = disp_src0_rdy_i | (disp_psrc0_i == '0) | disp_wake0;
        rdy1_d[i] = disp_src1_rdy_i | (disp_psrc1_i == '0) | disp_wake1;
      end
    end
  end

  // Occupancy and readiness state; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count_q <= '0;
      rdy0_q  <= '0;
      rdy1_q  <= '0;
    end else begin
      count_q <= count_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
    end
  end

  // Payload storage carries no reset since validity comes from the count
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

  assign iss_grand_op_o = ent_q[sel_idx].grand_op;
  assign iss_op_o       = ent_q[sel_idx].op;
  assign iss_pc_o       = ent_q[sel_idx].pc;
  assign iss_imm_o      = ent_q[sel_idx].imm;
  assign iss_psrc0_o    = ent_q[sel_idx].psrc0;
  assign iss_psrc1_o    = ent_q[sel_idx].psrc1;
  assign iss_pdst_o     = ent_q[sel_idx].pdst;

endmodule

// File: tb/tb_e_alu_iq.sv
// tb_e_alu_iq: scenario-driven bench for the ALU issue queue. Expected issue
// order is queued as stimulus is driven and compared as the queue issues.

module tb_e_alu_iq;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int WK_N  = 2;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    logic [2:0]       grand_op;
    logic [2:0]       op;
    logic [31:0]      pc;
    logic [TAG_W-1:0] pdst;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush_i;
  logic                  disp_valid_i;
  logic                  disp_ready_o;
  logic [2:0]            disp_grand_op_i;
  logic [2:0]            disp_op_i;
  logic [31:0]           disp_pc_i;
  logic [31:0]           disp_imm_i;
  logic [TAG_W-1:0]      disp_psrc0_i;
  logic [TAG_W-1:0]      disp_psrc1_i;
  logic                  disp_src0_rdy_i;
  logic                  disp_src1_rdy_i;
  logic [TAG_W-1:0]      disp_pdst_i;
  logic [WK_N-1:0]       wk_valid_i;
  logic [WK_N*TAG_W-1:0] wk_tag_i;
  logic                  iss_valid_o;
  logic                  iss_ready_i;
  logic [2:0]            iss_grand_op_o;
  logic [2:0]            iss_op_o;
  logic [31:0]           iss_pc_o;
  logic [31:0]           iss_imm_o;
  logic [TAG_W-1:0]      iss_psrc0_o;
  logic [TAG_W-1:0]      iss_psrc1_o;
  logic [TAG_W-1:0]      iss_pdst_o;
  logic [CW-1:0]         count_o;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  e_alu_iq #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WK_N(WK_N)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_grand_op_i(disp_grand_op_i), .disp_op_i(disp_op_i),
    .disp_pc_i(disp_pc_i), .disp_imm_i(disp_imm_i),
    .disp_psrc0_i(disp_psrc0_i), .disp_psrc1_i(disp_psrc1_i),
    .disp_src0_rdy_i(disp_src0_rdy_i), .disp_src1_rdy_i(disp_src1_rdy_i),
    .disp_pdst_i(disp_pdst_i),
    .wk_valid_i(wk_valid_i), .wk_tag_i(wk_tag_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_grand_op_o(iss_grand_op_o), .iss_op_o(iss_op_o),
    .iss_pc_o(iss_pc_o), .iss_imm_o(iss_imm_o),
    .iss_psrc0_o(iss_psrc0_o), .iss_psrc1_o(iss_psrc1_o),
    .iss_pdst_o(iss_pdst_o), .count_o(count_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one dispatch offer; optionally record it as the next expected issue
  task automatic applyStimulus(input logic [2:0] g, input logic [2:0] o, input logic [31:0] pc,
                               input logic [TAG_W-1:0] s0, input logic r0,
                               input logic [TAG_W-1:0] s1, input logic r1, input logic push);
    exp_t e;
    disp_valid_i    = 1'b1;
    disp_grand_op_i = g;
    disp_op_i       = o;
    disp_pc_i       = pc;
    disp_imm_i      = pc ^ 32'h5a5a_0000;
    disp_psrc0_i    = s0;
    disp_src0_rdy_i = r0;
    disp_psrc1_i    = s1;
    disp_src1_rdy_i = r1;
    disp_pdst_i     = TAG_W'(pc[7:2] + 6'd1);
    if (push) begin
      e.grand_op = g; e.op = o; e.pc = pc; e.pdst = TAG_W'(pc[7:2] + 6'd1);
      sb.push_back(e);
    end
  endtask

  task automatic push_exp(input logic [2:0] g, input logic [2:0] o, input logic [31:0] pc);
    exp_t e;
    e.grand_op = g; e.op = o; e.pc = pc; e.pdst = TAG_W'(pc[7:2] + 6'd1);
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    disp_valid_i = 1'b0;
    wk_valid_i   = '0;
    wk_tag_i     = '0;
    flush_i      = 1'b0;
  endtask

  task automatic wait_empty(input int max_cycles);
    for (int i = 0; i < max_cycles && count_o != '0; i++) tick();
  endtask

  // Compare every accepted issue against the head of the scoreboard
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && iss_valid_o && iss_ready_i) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL issue_unexpected pc=%h required no issue", iss_pc_o);
        end else begin
          e = sb.pop_front();
          if (iss_pc_o !== e.pc || iss_grand_op_o !== e.grand_op ||
              iss_op_o !== e.op || iss_pdst_o !== e.pdst || iss_imm_o !== (e.pc ^ 32'h5a5a_0000)) begin
            tests_failed++;
            $display("[TB] FAIL issue_payload pc=%h g=%0d op=%0d pdst=%0d required pc=%h g=%0d op=%0d pdst=%0d",
                     iss_pc_o, iss_grand_op_o, iss_op_o, iss_pdst_o, e.pc, e.grand_op, e.op, e.pdst);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iss_ready_i = 1'b0; idle_inputs();
    tick(); tick();
    rst = 1'b0;
    tests_run++;
    if (iss_valid_o !== 1'b0 || disp_ready_o !== 1'b1 || count_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state valid=%b ready=%b count=%0d required 0 1 0", iss_valid_o, disp_ready_o, count_o);
    end
  endtask

  task automatic test_in_order();
    iss_ready_i = 1'b1;
    applyStimulus(3'd0, 3'd0, 32'h1000, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1); tick();
    applyStimulus(3'd0, 3'd1, 32'h1004, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1); tick();
    applyStimulus(3'd1, 3'd2, 32'h1008, 6'd3, 1'b1, 6'd4, 1'b1, 1'b1); tick();
    disp_valid_i = 1'b0;
    tests_run++;
    if (count_o !== CW'(1) || iss_valid_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL in_order_pipe count=%0d valid=%b required 1 1", count_o, iss_valid_o);
    end
    tick();
    tests_run++;
    if (count_o !== '0 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL in_order_drain count=%0d pending=%0d required 0 0", count_o, sb.size());
    end
  endtask

  task automatic test_wakeup();
    iss_ready_i = 1'b0;
    applyStimulus(3'd0, 3'd0, 32'h1100, 6'd5, 1'b0, 6'd0, 1'b0, 1'b0); tick();
    applyStimulus(3'd2, 3'd3, 32'h1104, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1); tick();
    disp_valid_i = 1'b0;
    tests_run++;
    if (iss_valid_o !== 1'b1 || iss_pc_o !== 32'h1104) begin
      tests_failed++;
      $display("[TB] FAIL younger_ready_first valid=%b pc=%h required 1 00001104", iss_valid_o, iss_pc_o);
    end
    iss_ready_i = 1'b1;
    tick();
    wk_valid_i = 2'b01; wk_tag_i = {6'd0, 6'd5};
    #1;
    tests_run++;
    if (iss_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wakeup_same_cycle valid=%b required 0", iss_valid_o);
    end
    push_exp(3'd0, 3'd0, 32'h1100);
    tick();
    wk_valid_i = '0;
    tests_run++;
    if (iss_valid_o !== 1'b1 || iss_pc_o !== 32'h1100) begin
      tests_failed++;
      $display("[TB] FAIL wakeup_next_cycle valid=%b pc=%h required 1 00001100", iss_valid_o, iss_pc_o);
    end
    tick();
    tests_run++;
    if (count_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL wakeup_drain count=%0d required 0", count_o);
    end
  endtask

  task automatic test_full();
    iss_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(3'd1, 3'(i), 32'h2000 + 32'(4*i), 6'd0, 1'b0, 6'd9, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(3'd7, 3'd7, 32'h2ff0, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (disp_ready_o !== 1'b0 || count_o !== CW'(DEPTH) || iss_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_state ready=%b count=%0d valid=%b required 0 8 0", disp_ready_o, count_o, iss_valid_o);
    end
    wk_valid_i = 2'b10; wk_tag_i = {6'd9, 6'd0};
    tick();
    wk_valid_i = '0;
    iss_ready_i = 1'b1;
    tick();
    disp_valid_i = 1'b0;
    tests_run++;
    if (disp_ready_o !== 1'b1 || count_o !== CW'(DEPTH-1)) begin
      tests_failed++;
      $display("[TB] FAIL full_first_issue ready=%b count=%0d required 1 7", disp_ready_o, count_o);
    end
    wait_empty(DEPTH + 2);
    tests_run++;
    if (count_o !== '0 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL full_drain count=%0d pending=%0d required 0 0", count_o, sb.size());
    end
  endtask

  task automatic test_bypass();
    iss_ready_i = 1'b0;
    applyStimulus(3'd0, 3'd4, 32'h3000, 6'd7, 1'b0, 6'd0, 1'b0, 1'b1);
    wk_valid_i = 2'b10; wk_tag_i = {6'd7, 6'd0};
    tick();
    idle_inputs();
    tests_run++;
    if (iss_valid_o !== 1'b1 || iss_pc_o !== 32'h3000) begin
      tests_failed++;
      $display("[TB] FAIL bypass_wakeup valid=%b pc=%h required 1 00003000", iss_valid_o, iss_pc_o);
    end
    iss_ready_i = 1'b1;
    tick();
    iss_ready_i = 1'b0;
    applyStimulus(3'd3, 3'd1, 32'h3004, 6'd12, 1'b0, 6'd12, 1'b0, 1'b1); tick();
    disp_valid_i = 1'b0;
    wk_valid_i = 2'b11; wk_tag_i = {6'd12, 6'd12};
    tick();
    wk_valid_i = '0;
    tests_run++;
    if (iss_valid_o !== 1'b1 || iss_pc_o !== 32'h3004) begin
      tests_failed++;
      $display("[TB] FAIL same_tag_both_srcs valid=%b pc=%h required 1 00003004", iss_valid_o, iss_pc_o);
    end
    iss_ready_i = 1'b1;
    tick();
    tests_run++;
    if (count_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL bypass_drain count=%0d required 0", count_o);
    end
  endtask

  task automatic test_back_to_back();
    iss_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'd2, 3'(i), 32'h4000 + 32'(4*i), 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
      tick();
    end
    disp_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (iss_pc_o !== 32'h4000 || count_o !== CW'(4) || iss_valid_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL hold_cycle%0d pc=%h count=%0d required 00004000 4", c, iss_pc_o, count_o);
      end
      tick();
    end
    iss_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'd4, 3'(i), 32'h5000 + 32'(4*i), 6'd0, 1'b1, 6'd0, 1'b1, 1'b1);
      tick();
      tests_run++;
      if (count_o !== CW'(4)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_count%0d count=%0d required 4", i, count_o);
      end
    end
    disp_valid_i = 1'b0;
    wait_empty(8);
    tests_run++;
    if (count_o !== '0 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_drain count=%0d pending=%0d required 0 0", count_o, sb.size());
    end
  endtask

  task automatic test_flush_reset();
    iss_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'd5, 3'd0, 32'h6000 + 32'(4*i), 6'd0, 1'b1, 6'd0, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(3'd5, 3'd1, 32'h6100, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0);
    flush_i = 1'b1; iss_ready_i = 1'b1;
    #1;
    tests_run++;
    if (iss_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_valid valid=%b required 0", iss_valid_o);
    end
    tick();
    idle_inputs();
    iss_ready_i = 1'b0;
    tests_run++;
    if (count_o !== '0 || iss_valid_o !== 1'b0 || disp_ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_empty count=%0d valid=%b ready=%b required 0 0 1", count_o, iss_valid_o, disp_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd6, 3'd0, 32'h7000 + 32'(4*i), 6'd0, 1'b1, 6'd0, 1'b1, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    disp_valid_i = 1'b0;
    tests_run++;
    if (count_o !== '0 || iss_valid_o !== 1'b0 || disp_ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midfill_reset count=%0d valid=%b ready=%b required 0 0 1", count_o, iss_valid_o, disp_ready_o);
    end
    iss_ready_i = 1'b1;
    applyStimulus(3'd6, 3'd5, 32'h7100, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1); tick();
    disp_valid_i = 1'b0;
    tick();
    tests_run++;
    if (count_o !== '0 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_issue count=%0d pending=%0d required 0 0", count_o, sb.size());
    end
  endtask

  // Run each scenario in order, then report
  initial begin
    rst = 1'b1;
    iss_ready_i = 1'b0;
    idle_inputs();
    disp_grand_op_i = '0; disp_op_i = '0; disp_pc_i = '0; disp_imm_i = '0;
    disp_psrc0_i = '0; disp_psrc1_i = '0; disp_src0_rdy_i = 1'b0; disp_src1_rdy_i = 1'b0;
    disp_pdst_i = '0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_in_order();
    test_wakeup();
    test_full();
    test_bypass();
    test_back_to_back();
    test_flush_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
